// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit with its sequencing FSM.
//   Multiply: radix-2 Booth, one step per cycle, WIDTH cycles.
//   Divide:   restoring division on magnitudes, one quotient bit per cycle,
//             with sign fix-up when the result registers load.
// Ports:
//   clk, reset (sync, active-low)
//   mult_start / div_start : one-cycle requests, sampled only in IDLE
//   a_in / b_in            : multiplicand/dividend, multiplier/divisor
//   busy                   : high while MULT/DIV iterate
//   done                   : one-cycle completion pulse (hi_out/lo_out valid)
//   div_zero               : one-cycle pulse for a divide with b_in == 0
//   hi_out / lo_out        : mult {hi,lo} product; div remainder/quotient
// Optional: define MULDIV_UNSIGNED_EN to add is_unsigned (multu/divu).
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_MULT, S_DIV, S_FINISH, S_DZERO
    } state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     r_acc;    // mult: upper accumulator; div: partial remainder
    logic [WIDTH-1:0]   r_lo;     // mult: multiplier/low product; div: dividend/quotient
    logic               r_q1;     // Booth q[-1]
    logic [WIDTH:0]     r_m;      // mult: extended multiplicand; div: divisor magnitude
    logic               r_fa;     // div: negate remainder
    logic               r_fb;     // mult: unsigned multiplier correction; div: negate quotient
    logic               r_busy, r_done, r_dz;
    logic [WIDTH-1:0]   r_hi, r_lo_out;

    logic               w_uns;
    logic               w_last;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_booth_sum;
    logic [WIDTH:0]     w_mul_acc;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_sub;
    logic               w_ge;
    logic [WIDTH:0]     w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;

`ifdef MULDIV_UNSIGNED_EN
    assign w_uns = is_unsigned;
`else
    assign w_uns = 1'b0;
`endif

    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_a_neg = ~w_uns & a_in[WIDTH-1];
    assign w_b_neg = ~w_uns & b_in[WIDTH-1];
    assign w_a_mag = w_a_neg ? (WIDTH'(0) - a_in) : a_in;
    assign w_b_mag = w_b_neg ? (WIDTH'(0) - b_in) : b_in;

    // Booth step: add/sub multiplicand per {q0,q-1}, then arithmetic shift right
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_lo[0], r_q1})
            2'b01:   w_booth_sum = r_acc + r_m;
            2'b10:   w_booth_sum = r_acc - r_m;
            default: w_booth_sum = r_acc;
        endcase
    end
    assign w_mul_acc = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
    assign w_mul_lo  = {w_booth_sum[0], r_lo[WIDTH-1:1]};
    // Multiplier was iterated as signed; an unsigned multiplier with its MSB set
    // is short by a * 2^WIDTH, added back into the high half.
    assign w_mul_hi  = w_mul_acc[WIDTH-1:0] + (r_fb ? r_m[WIDTH-1:0] : WIDTH'(0));

    // Restoring divide step: shift in next dividend bit, subtract if it fits
    assign w_rem_sh  = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_sub     = w_rem_sh - {1'b0, r_m[WIDTH-1:0]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_m[WIDTH-1:0]});
    assign w_div_rem = w_ge ? w_sub : w_rem_sh;
    assign w_div_quo = {r_lo[WIDTH-2:0], w_ge};

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mult_start)     w_next = S_MULT;
                else if (div_start) w_next = (b_in == WIDTH'(0)) ? S_DZERO : S_DIV;
            end
            S_MULT:   if (w_last) w_next = S_FINISH;
            S_DIV:    if (w_last) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            S_DZERO:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_q1     <= 1'b0;
            r_m      <= '0;
            r_fa     <= 1'b0;
            r_fb     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo_out <= '0;
        end else begin
            r_busy <= (w_next == S_MULT) || (w_next == S_DIV);
            r_done <= (w_next == S_FINISH) || (w_next == S_DZERO);
            r_dz   <= (w_next == S_DZERO);
            case (r_state)
                S_IDLE: begin
                    if (mult_start) begin
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_lo  <= b_in;
                        r_q1  <= 1'b0;
                        r_m   <= {~w_uns & a_in[WIDTH-1], a_in};
                        r_fa  <= 1'b0;
                        r_fb  <= w_uns & b_in[WIDTH-1];
                    end else if (div_start && (b_in != WIDTH'(0))) begin
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_lo  <= w_a_mag;
                        r_q1  <= 1'b0;
                        r_m   <= {1'b0, w_b_mag};
                        r_fa  <= w_a_neg;
                        r_fb  <= w_a_neg ^ w_b_neg;
                    end
                end
                S_MULT: begin
                    r_acc <= w_mul_acc;
                    r_lo  <= w_mul_lo;
                    r_q1  <= r_lo[0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi     <= w_mul_hi;
                        r_lo_out <= w_mul_lo;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_rem;
                    r_lo  <= w_div_quo;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi     <= r_fa ? (WIDTH'(0) - w_div_rem[WIDTH-1:0]) : w_div_rem[WIDTH-1:0];
                        r_lo_out <= r_fb ? (WIDTH'(0) - w_div_quo) : w_div_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo_out;

endmodule
